// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// A single bit-serial datapath performs radix-2 shift-add multiplication
// and restoring division on operand magnitudes; signs are applied in one
// fix-up step when the result is loaded. Divide-by-zero and signed overflow
// bypass the iteration and complete in one cycle.
module mul_div_unit #(
    parameter int DWIDTH = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MD_Start,
    input  logic [2:0]        MD_Op,
    input  logic [DWIDTH-1:0] MD_In_A,
    input  logic [DWIDTH-1:0] MD_In_B,
    output logic              MD_Busy,
    output logic              MD_Done,
    output logic [DWIDTH-1:0] MD_Out
);

    localparam int CW = $clog2(DWIDTH);
    localparam int PW = 2 * DWIDTH;

    localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     CNT_LAST = {CW{1'b1}};
    localparam logic [DWIDTH-1:0] ZERO_W   = {DWIDTH{1'b0}};
    localparam logic [DWIDTH-1:0] ONES_W   = {DWIDTH{1'b1}};
    localparam logic [DWIDTH-1:0] MIN_W    = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic [DWIDTH-1:0] ONE_W    = {{(DWIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]     ONE_P    = {{(PW-1){1'b0}}, 1'b1};

    // funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's complement negation at operand width.
    function automatic logic [DWIDTH-1:0] neg_w(input logic [DWIDTH-1:0] v);
        return (~v) + ONE_W;
    endfunction

    // Two's complement negation at product width.
    function automatic logic [PW-1:0] neg_p(input logic [PW-1:0] v);
        return (~v) + ONE_P;
    endfunction

    // Magnitude of an operand; unsigned operands pass through unchanged.
    function automatic logic [DWIDTH-1:0] mag_of(input logic [DWIDTH-1:0] v,
                                                 input logic is_neg);
        return is_neg ? neg_w(v) : v;
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic [2:0]          op_r;
    logic                sign_a_r;
    logic                sign_b_r;
    logic [DWIDTH-1:0]   mag_a_r;
    logic [DWIDTH-1:0]   mag_b_r;
    logic [CW-1:0]       cnt_r;
    logic [PW-1:0]       acc_r;
    logic [DWIDTH-1:0]   quo_r;
    logic [DWIDTH-1:0]   rem_r;
    logic [DWIDTH-1:0]   out_r;
    logic                busy_r;
    logic                done_r;

    logic                launch_s;
    logic                a_signed_s;
    logic                b_signed_s;
    logic                sign_a_s;
    logic                sign_b_s;
    logic                div_zero_s;
    logic                div_ovf_s;
    logic                fast_s;
    logic [DWIDTH-1:0]   fast_result_s;

    logic [DWIDTH:0]     mul_sum_s;
    logic [PW-1:0]       acc_step_s;
    logic [DWIDTH:0]     rem_shift_s;
    logic                rem_ge_s;
    logic [DWIDTH-1:0]   rem_step_s;
    logic [DWIDTH-1:0]   quo_step_s;
    logic [PW-1:0]       prod_fix_s;
    logic [DWIDTH-1:0]   quo_fix_s;
    logic [DWIDTH-1:0]   rem_fix_s;
    logic [DWIDTH-1:0]   calc_result_s;

    // A launch is accepted whenever the unit is not iterating.
    assign launch_s = MD_Start && (state_r != ST_CALC);

    // Decode operand signedness, special cases and the fast-path result.
    always_comb begin
        a_signed_s    = 1'b0;
        b_signed_s    = 1'b0;
        fast_result_s = ZERO_W;
        if (MD_Op[2]) begin
            // DIV/REM signed, DIVU/REMU unsigned
            a_signed_s = ~MD_Op[0];
            b_signed_s = ~MD_Op[0];
        end else begin
            // MUL/MULH both signed, MULHSU only A signed, MULHU unsigned
            a_signed_s = (MD_Op != OP_MULHU);
            b_signed_s = ~MD_Op[1];
        end
        sign_a_s   = a_signed_s & MD_In_A[DWIDTH-1];
        sign_b_s   = b_signed_s & MD_In_B[DWIDTH-1];
        div_zero_s = MD_Op[2] && (MD_In_B == ZERO_W);
        div_ovf_s  = MD_Op[2] && !MD_Op[0] && (MD_In_A == MIN_W) && (MD_In_B == ONES_W);
        fast_s     = div_zero_s || div_ovf_s;
        // MD_Op[1] distinguishes remainder from quotient among divide ops
        if (div_zero_s) begin
            fast_result_s = MD_Op[1] ? MD_In_A : ONES_W;
        end else if (div_ovf_s) begin
            fast_result_s = MD_Op[1] ? ZERO_W : MD_In_A;
        end else begin
            fast_result_s = ZERO_W;
        end
    end

    // One bit step of shift-add multiply and restoring divide.
    always_comb begin
        // Multiply: add |A| into the upper half when the multiplier LSB is set,
        // then shift the whole accumulator right; the lower half starts as |B|.
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[PW-1:DWIDTH]} + {1'b0, mag_a_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[PW-1:DWIDTH]};
        end
        acc_step_s = {mul_sum_s, acc_r[DWIDTH-1:1]};

        // Divide: quotient register starts as |A| and shifts dividend bits
        // into the partial remainder while quotient bits shift in from the right.
        rem_shift_s = {rem_r, quo_r[DWIDTH-1]};
        rem_ge_s    = (rem_shift_s >= {1'b0, mag_b_r});
        if (rem_ge_s) begin
            rem_step_s = rem_shift_s[DWIDTH-1:0] - mag_b_r;
        end else begin
            rem_step_s = rem_shift_s[DWIDTH-1:0];
        end
        quo_step_s = {quo_r[DWIDTH-2:0], rem_ge_s};
    end

    // Sign fix-up and result selection for the final iteration.
    always_comb begin
        prod_fix_s = (sign_a_r ^ sign_b_r) ? neg_p(acc_step_s) : acc_step_s;
        quo_fix_s  = (sign_a_r ^ sign_b_r) ? neg_w(quo_step_s) : quo_step_s;
        rem_fix_s  = sign_a_r ? neg_w(rem_step_s) : rem_step_s;
        case (op_r)
            OP_MUL:    calc_result_s = prod_fix_s[DWIDTH-1:0];
            OP_MULH:   calc_result_s = prod_fix_s[PW-1:DWIDTH];
            OP_MULHSU: calc_result_s = prod_fix_s[PW-1:DWIDTH];
            OP_MULHU:  calc_result_s = prod_fix_s[PW-1:DWIDTH];
            OP_DIV:    calc_result_s = quo_fix_s;
            OP_DIVU:   calc_result_s = quo_fix_s;
            OP_REM:    calc_result_s = rem_fix_s;
            OP_REMU:   calc_result_s = rem_fix_s;
            default:   calc_result_s = ZERO_W;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (launch_s) begin
                    state_next_s = fast_s ? ST_DONE : ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Operand capture, iteration registers and result register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            op_r     <= 3'b000;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            mag_a_r  <= ZERO_W;
            mag_b_r  <= ZERO_W;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {PW{1'b0}};
            quo_r    <= ZERO_W;
            rem_r    <= ZERO_W;
            out_r    <= ZERO_W;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (launch_s) begin
                        op_r     <= MD_Op;
                        sign_a_r <= sign_a_s;
                        sign_b_r <= sign_b_s;
                        mag_a_r  <= mag_of(MD_In_A, sign_a_s);
                        mag_b_r  <= mag_of(MD_In_B, sign_b_s);
                        cnt_r    <= {CW{1'b0}};
                        acc_r    <= {ZERO_W, mag_of(MD_In_B, sign_b_s)};
                        quo_r    <= mag_of(MD_In_A, sign_a_s);
                        rem_r    <= ZERO_W;
                        if (fast_s) begin
                            out_r <= fast_result_s;
                        end
                    end
                end
                ST_CALC: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    acc_r <= acc_step_s;
                    quo_r <= quo_step_s;
                    rem_r <= rem_step_s;
                    if (cnt_r == CNT_LAST) begin
                        out_r <= calc_result_s;
                    end
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Registered handshake flags derived from the upcoming state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_CALC);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    assign MD_Busy = busy_r;
    assign MD_Done = done_r;
    assign MD_Out  = out_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         Clk      = 1'b0;
    logic         Reset    = 1'b0;
    logic         MD_Start = 1'b0;
    logic [2:0]   MD_Op    = 3'b000;
    logic [W-1:0] MD_In_A  = 32'h0;
    logic [W-1:0] MD_In_B  = 32'h0;
    logic         MD_Busy;
    logic         MD_Done;
    logic [W-1:0] MD_Out;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.DWIDTH(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .MD_Start (MD_Start),
        .MD_Op    (MD_Op),
        .MD_In_A  (MD_In_A),
        .MD_In_B  (MD_In_B),
        .MD_Busy  (MD_Busy),
        .MD_Done  (MD_Done),
        .MD_Out   (MD_Out)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Reference result computed from the RV32M rules with plain arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic        ovf;
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        ea  = {32'h0, a};
        eb  = {32'h0, b};
        if (op != 3'd3) ea = {{32{a[31]}}, a};
        if (op <= 3'd1) eb = {{32{b[31]}}, b};
        p = ea * eb;
        case (op)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: begin
                if (b == 32'h0) return 32'hFFFFFFFF;
                if (ovf) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 32'h0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Expected start-to-done latency in cycles.
    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op[2] && (b == 32'h0)) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return W + 1;
    endfunction

    // Launch one operation now, track busy/done timing and check the result.
    // noisy: toggle MD_Start and inputs while the unit is iterating.
    // hold: idle cycles afterwards in which the result must stay and no done appears.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit noisy, input int hold,
                          output logic [31:0] res);
        int          exp_lat;
        int          n;
        int          busy_n;
        logic [31:0] exp_v;
        exp_v   = ref_md(op, a, b);
        exp_lat = ref_lat(op, a, b);
        MD_Start = 1'b1;
        MD_Op    = op;
        MD_In_A  = a;
        MD_In_B  = b;
        step();
        n      = 1;
        busy_n = 0;
        MD_Start = 1'b0;
        MD_Op    = 3'($urandom);
        MD_In_A  = $urandom;
        MD_In_B  = $urandom;
        while (!MD_Done && n < 200) begin
            if (MD_Busy) busy_n++;
            if (noisy && n < exp_lat) begin
                MD_Start = 1'($urandom_range(0, 1));
                MD_Op    = 3'($urandom);
                MD_In_A  = $urandom;
                MD_In_B  = $urandom;
            end else begin
                MD_Start = 1'b0;
            end
            step();
            n++;
        end
        MD_Start = 1'b0;
        check_eq({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check_eq({tag, "_busy"}, 64'(busy_n), 64'(exp_lat - 1));
        check_eq({tag, "_out"}, {32'h0, MD_Out}, {32'h0, exp_v});
        res = MD_Out;
        for (int i = 0; i < hold; i++) begin
            step();
            check_eq({tag, "_hold_done"}, {63'h0, MD_Done}, 64'h0);
            check_eq({tag, "_hold_out"}, {32'h0, MD_Out}, {32'h0, exp_v});
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [2:0]  op;
        logic [31:0] a, b;
        int          dones;

        // Reset state
        #1 Reset = 1'b1;
        #1;
        check_eq("rst_busy", {63'h0, MD_Busy}, 64'h0);
        check_eq("rst_done", {63'h0, MD_Done}, 64'h0);
        check_eq("rst_out", {32'h0, MD_Out}, 64'h0);
        step();
        step();
        Reset = 1'b0;
        step();

        // MUL 7 * -3 with result hold
        run_op("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 1'b0, 7, r);
        check_eq("mul_const", {32'h0, r}, 64'hFFFFFFEB);

        // MULH / MULHSU / MULHU back to back
        run_op("mulh", 3'd1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0, r);
        check_eq("mulh_const", {32'h0, r}, 64'h00000000);
        run_op("mulhsu", 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0, r);
        check_eq("mulhsu_const", {32'h0, r}, 64'h80000000);
        run_op("mulhu", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 2, r);
        check_eq("mulhu_const", {32'h0, r}, 64'h7FFFFFFF);

        // Division and remainder
        run_op("div", 3'd4, 32'hFFFFFFF9, 32'd2, 1'b0, 1, r);
        check_eq("div_const", {32'h0, r}, 64'hFFFFFFFD);
        run_op("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 1'b0, 1, r);
        check_eq("rem_const", {32'h0, r}, 64'hFFFFFFFF);
        run_op("divu", 3'd5, 32'd100, 32'd7, 1'b0, 1, r);
        check_eq("divu_const", {32'h0, r}, 64'd14);
        run_op("remu", 3'd7, 32'd100, 32'd7, 1'b0, 1, r);
        check_eq("remu_const", {32'h0, r}, 64'd2);

        // Fast paths: divide by zero and signed overflow
        run_op("divu0", 3'd5, 32'h12345678, 32'h0, 1'b0, 1, r);
        check_eq("divu0_const", {32'h0, r}, 64'hFFFFFFFF);
        run_op("rem0", 3'd6, 32'h12345678, 32'h0, 1'b0, 1, r);
        check_eq("rem0_const", {32'h0, r}, 64'h12345678);
        run_op("ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1, r);
        check_eq("ovf_const", {32'h0, r}, 64'h80000000);

        // Reset in the middle of a MUL
        MD_Start = 1'b1;
        MD_Op    = 3'd0;
        MD_In_A  = 32'd1234;
        MD_In_B  = 32'd5678;
        step();
        MD_Start = 1'b0;
        repeat (9) step();
        check_eq("abort_busy_pre", {63'h0, MD_Busy}, 64'h1);
        #2 Reset = 1'b1;
        #1;
        check_eq("abort_busy", {63'h0, MD_Busy}, 64'h0);
        check_eq("abort_done", {63'h0, MD_Done}, 64'h0);
        check_eq("abort_out", {32'h0, MD_Out}, 64'h0);
        step();
        Reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (MD_Done) dones++;
        end
        check_eq("abort_no_done", 64'(dones), 64'h0);
        run_op("mul35", 3'd0, 32'd3, 32'd5, 1'b0, 1, r);
        check_eq("mul35_const", {32'h0, r}, 64'd15);

        // Start requests during CALC must be ignored
        run_op("noisy_mul", 3'd0, 32'h0001E240, 32'hFFFF0001, 1'b1, 5, r);
        run_op("noisy_div", 3'd4, 32'h87654321, 32'd1000, 1'b1, 5, r);

        // Randomized operations, some back to back and some with noise
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                4: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op("rand", op, a, b, (i % 5) == 0,
                   ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 3), r);
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
